// File: rtl/vending_controller_gen2_if.sv
// Signal bundle between the vending controller, the front-panel/coin pulse logic and the dispensers.
// The master side drives buttons, coins, prices and acks; the slave side is the controller.
interface vending_controller_gen2_if #(
   parameter int NUM_ITEMS = 4,
   parameter int IDX_W     = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1,
   parameter int CREDIT_W  = 6,
   parameter int PRICE_W   = 4
);
   logic                         i_coin_valid;
   logic [CREDIT_W-1:0]          i_coin_units;
   logic                         i_sel_valid;
   logic [IDX_W-1:0]             i_sel_idx;
   logic                         i_refund;
   logic                         i_restock;
   logic [NUM_ITEMS*PRICE_W-1:0] i_prices;
   logic [CREDIT_W-1:0]          o_credit;
   logic                         o_coin_reject;
   logic                         o_item_valid;
   logic [IDX_W-1:0]             o_item_idx;
   logic                         i_item_ack;
   logic                         o_change_req;
   logic                         i_change_ack;
   logic                         o_err_valid;
   logic [1:0]                   o_err_code;
   logic [NUM_ITEMS-1:0]         o_sold_out;

   modport master (
      output i_coin_valid, i_coin_units, i_sel_valid, i_sel_idx, i_refund, i_restock,
             i_prices, i_item_ack, i_change_ack,
      input  o_credit, o_coin_reject, o_item_valid, o_item_idx, o_change_req,
             o_err_valid, o_err_code, o_sold_out
   );

   modport slave (
      input  i_coin_valid, i_coin_units, i_sel_valid, i_sel_idx, i_refund, i_restock,
             i_prices, i_item_ack, i_change_ack,
      output o_credit, o_coin_reject, o_item_valid, o_item_idx, o_change_req,
             o_err_valid, o_err_code, o_sold_out
   );
endinterface

// File: rtl/vending_controller_gen2.sv
// Vending controller: saturating coin credit, priced item vend with per-item stock,
// and one-unit-at-a-time change return. All outputs are registered.
module vending_controller_gen2 #(
   parameter int NUM_ITEMS  = 4,
   parameter int IDX_W      = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1,
   parameter int CREDIT_W   = 6,
   parameter int MAX_CREDIT = 16,
   parameter int PRICE_W    = 4,
   parameter int STOCK_W    = 4,
   parameter int INIT_STOCK = 5
) (
   input logic                     i_clk,
   input logic                     i_rst_n,
   vending_controller_gen2_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

   state_t               state_q, state_d;
   logic [CREDIT_W-1:0]  credit_q, credit_d;
   logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
   logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
   logic                 coin_reject_q, coin_reject_d;
   logic                 item_valid_q, item_valid_d;
   logic [IDX_W-1:0]     item_idx_q, item_idx_d;
   logic                 change_req_q, change_req_d;
   logic                 err_valid_q, err_valid_d;
   logic [1:0]           err_code_q, err_code_d;
   logic [NUM_ITEMS-1:0] sold_out_q, sold_out_d;

   logic [NUM_ITEMS-1:0] sel_hit;
   logic                 sel_in_range;
   logic [PRICE_W-1:0]   sel_price;
   logic [STOCK_W-1:0]   sel_stock;
   logic [CREDIT_W:0]    coin_sum;

   // One-hot decode of the selected index; an out-of-range index decodes to all zeros.
   for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_item
      assign sel_hit[gi]    = (bus.i_sel_idx == IDX_W'(gi));
      assign sold_out_d[gi] = (stock_d[gi] == '0);
   end

   assign sel_in_range = |sel_hit;
   assign coin_sum     = {1'b0, credit_q} + {1'b0, bus.i_coin_units};

   always_comb begin
      sel_price = '0;
      sel_stock = '0;
      for (int k = 0; k < NUM_ITEMS; k++) begin
         if (sel_hit[k]) begin
            sel_price = bus.i_prices[k*PRICE_W +: PRICE_W];
            sel_stock = stock_q[k];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      stock_d       = stock_q;
      coin_reject_d = 1'b0;
      item_valid_d  = item_valid_q;
      item_idx_d    = item_idx_q;
      change_req_d  = change_req_q;
      err_valid_d   = 1'b0;
      err_code_d    = 2'b00;

      if (bus.i_restock) begin
         for (int k = 0; k < NUM_ITEMS; k++) begin
            if (sel_hit[k]) stock_d[k] = STOCK_W'(INIT_STOCK);
         end
      end

      // Refund outranks coin, coin outranks select; lower-priority events are dropped.
      if (bus.i_refund) begin
         coin_reject_d = bus.i_coin_valid;
         if (state_q == CREDIT) begin
            state_d      = CHANGE;
            change_req_d = 1'b1;
         end
      end else if (bus.i_coin_valid) begin
         if ((state_q == IDLE || state_q == CREDIT) && coin_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = (coin_sum[CREDIT_W-1:0] != '0) ? CREDIT : state_q;
         end else begin
            coin_reject_d = 1'b1;
         end
      end else if (bus.i_sel_valid && !bus.i_restock && state_q == CREDIT) begin
         if (!sel_in_range) begin
            err_valid_d = 1'b1;
            err_code_d  = 2'b11;
         end else if (sel_stock == '0) begin
            err_valid_d = 1'b1;
            err_code_d  = 2'b10;
         end else if (credit_q < CREDIT_W'(sel_price)) begin
            err_valid_d = 1'b1;
            err_code_d  = 2'b01;
         end else begin
            credit_d     = credit_q - CREDIT_W'(sel_price);
            item_valid_d = 1'b1;
            item_idx_d   = bus.i_sel_idx;
            state_d      = VEND;
            for (int k = 0; k < NUM_ITEMS; k++) begin
               if (sel_hit[k]) stock_d[k] = stock_q[k] - STOCK_W'(1);
            end
         end
      end

      case (state_q)
         VEND: begin
            if (bus.i_item_ack) begin
               item_valid_d = 1'b0;
               if (credit_q != '0) begin
                  state_d      = CHANGE;
                  change_req_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         CHANGE: begin
            if (bus.i_change_ack) begin
               credit_d = credit_q - CREDIT_W'(1);
               if (credit_q == CREDIT_W'(1)) begin
                  change_req_d = 1'b0;
                  state_d      = IDLE;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= IDLE;
         credit_q      <= '0;
         for (int k = 0; k < NUM_ITEMS; k++) stock_q[k] <= STOCK_W'(INIT_STOCK);
         coin_reject_q <= 1'b0;
         item_valid_q  <= 1'b0;
         item_idx_q    <= '0;
         change_req_q  <= 1'b0;
         err_valid_q   <= 1'b0;
         err_code_q    <= 2'b00;
         sold_out_q    <= {NUM_ITEMS{(INIT_STOCK == 0)}};
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         stock_q       <= stock_d;
         coin_reject_q <= coin_reject_d;
         item_valid_q  <= item_valid_d;
         item_idx_q    <= item_idx_d;
         change_req_q  <= change_req_d;
         err_valid_q   <= err_valid_d;
         err_code_q    <= err_code_d;
         sold_out_q    <= sold_out_d;
      end
   end

   assign bus.o_credit      = credit_q;
   assign bus.o_coin_reject = coin_reject_q;
   assign bus.o_item_valid  = item_valid_q;
   assign bus.o_item_idx    = item_idx_q;
   assign bus.o_change_req  = change_req_q;
   assign bus.o_err_valid   = err_valid_q;
   assign bus.o_err_code    = err_code_q;
   assign bus.o_sold_out    = sold_out_q;
endmodule

// File: tb/tb_vending_controller_gen2.sv
// Randomised plus directed bench for vending_controller_gen2; a queue-based scoreboard
// compares every cycle's outputs against a transaction-level model of the vending rules.
module tb_vending_controller_gen2;
   localparam int NI   = 4;
   localparam int IW   = 3;
   localparam int CW   = 6;
   localparam int PW   = 4;
   localparam int INIT = 5;
   localparam int MAXC = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   vending_controller_gen2_if #(.NUM_ITEMS(NI), .IDX_W(IW), .CREDIT_W(CW), .PRICE_W(PW)) bus ();

   vending_controller_gen2 #(
      .NUM_ITEMS(NI), .IDX_W(IW), .CREDIT_W(CW), .MAX_CREDIT(MAXC),
      .PRICE_W(PW), .STOCK_W(4), .INIT_STOCK(INIT)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   typedef struct {
      int tgt;
      int credit;
      bit rej;
      bit iv;
      int iidx;
      bit cr;
      bit ev;
      int ec;
      int so;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model: credit in units, stock per item, and two activity flags.
   int m_credit;
   int m_stock[NI];
   bit m_vend;
   bit m_chg;
   int m_vidx;
   int price[NI];

   function automatic void chk(string name, int act, int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endfunction

   function automatic void model_reset();
      m_credit = 0;
      m_vend   = 0;
      m_chg    = 0;
      m_vidx   = 0;
      for (int k = 0; k < NI; k++) m_stock[k] = INIT;
   endfunction

   task automatic step(bit coin, int units, bit sel, int idx, bit refund, bit restock, bit iack, bit cack);
      exp_t e;
      bit   was_v;
      bit   was_c;
      was_v = m_vend;
      was_c = m_chg;
      bus.i_coin_valid = coin;
      bus.i_coin_units = CW'(units);
      bus.i_sel_valid  = sel;
      bus.i_sel_idx    = IW'(idx);
      bus.i_refund     = refund;
      bus.i_restock    = restock;
      bus.i_item_ack   = iack;
      bus.i_change_ack = cack;
      for (int k = 0; k < NI; k++) bus.i_prices[k*PW +: PW] = PW'(price[k]);

      e.rej = 0;
      e.ev  = 0;
      e.ec  = 0;
      if (restock && idx < NI) m_stock[idx] = INIT;
      if (refund) begin
         e.rej = coin;
         if (!was_v && !was_c && m_credit > 0) m_chg = 1;
      end else if (coin) begin
         if (!was_v && !was_c && m_credit + units <= MAXC) m_credit += units;
         else e.rej = 1;
      end else if (sel && !restock && !was_v && !was_c && m_credit > 0) begin
         if (idx >= NI) begin
            e.ev = 1; e.ec = 3;
         end else if (m_stock[idx] == 0) begin
            e.ev = 1; e.ec = 2;
         end else if (m_credit < price[idx]) begin
            e.ev = 1; e.ec = 1;
         end else begin
            m_credit -= price[idx];
            m_stock[idx]--;
            m_vend = 1;
            m_vidx = idx;
         end
      end
      if (was_v && iack) begin
         m_vend = 0;
         m_chg  = (m_credit > 0);
      end
      if (was_c && cack) begin
         m_credit--;
         if (m_credit == 0) m_chg = 0;
      end

      e.tgt    = cyc + 1;
      e.credit = m_credit;
      e.iv     = m_vend;
      e.iidx   = m_vidx;
      e.cr     = m_chg;
      e.so     = 0;
      for (int k = 0; k < NI; k++) if (m_stock[k] == 0) e.so |= (1 << k);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic coin(int u);
      step(1, u, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic sel(int i);
      step(0, 0, 1, i, 0, 0, 0, 0);
   endtask

   task automatic drain();
      for (int i = 0; i < 80 && (m_vend || m_chg || m_credit > 0); i++) begin
         if (!m_vend && !m_chg) step(0, 0, 0, 0, 1, 0, 0, 0);
         else step(0, 0, 0, 0, 0, 0, m_vend, m_chg && ($urandom_range(0, 3) != 0));
      end
      chk("drain_credit", int'(bus.o_credit), 0);
   endtask

   // Monitor: pops the record due for the edge just taken and compares every output.
   initial begin
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0 && sb_q[0].tgt == cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("credit", int'(bus.o_credit), e.credit);
            chk("coin_reject", int'(bus.o_coin_reject), int'(e.rej));
            chk("item_valid", int'(bus.o_item_valid), int'(e.iv));
            if (e.iv) chk("item_idx", int'(bus.o_item_idx), e.iidx);
            chk("change_req", int'(bus.o_change_req), int'(e.cr));
            chk("err_valid", int'(bus.o_err_valid), int'(e.ev));
            chk("err_code", int'(bus.o_err_code), e.ec);
            chk("sold_out", int'(bus.o_sold_out), e.so);
         end
      end
   end

   initial begin
      price[0] = 0; price[1] = 2; price[2] = 4; price[3] = 6;
      bus.i_coin_valid = 0; bus.i_coin_units = '0; bus.i_sel_valid = 0; bus.i_sel_idx = '0;
      bus.i_refund = 0; bus.i_restock = 0; bus.i_item_ack = 0; bus.i_change_ack = 0;
      bus.i_prices = {4'd6, 4'd4, 4'd2, 4'd0};
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      chk("rst_credit", int'(bus.o_credit), 0);
      chk("rst_item_valid", int'(bus.o_item_valid), 0);
      chk("rst_change_req", int'(bus.o_change_req), 0);
      chk("rst_err_valid", int'(bus.o_err_valid), 0);
      chk("rst_coin_reject", int'(bus.o_coin_reject), 0);
      chk("rst_sold_out", int'(bus.o_sold_out), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic vend with change
      coin(1); coin(4); sel(1);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1);
      idle(2);

      // Credit ceiling
      coin(4); coin(4); coin(4); coin(2);
      coin(4); coin(1); coin(1); coin(1);
      drain(); idle(1);

      // Select errors then refund
      coin(3); sel(3); sel(5);
      step(0, 0, 0, 0, 1, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1);
      idle(2);

      // Sell out item 0, then restock it
      price[0] = 2;
      repeat (5) begin
         coin(2); sel(0);
         step(0, 0, 0, 0, 0, 0, 1, 0);
         idle(1);
      end
      coin(2); sel(0);
      step(0, 0, 0, 0, 0, 1, 0, 0);
      idle(2);
      drain(); idle(1);

      // Same-cycle priorities and coin during vend
      coin(4);
      step(1, 1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 1, 0, 0, 0);
      drain(); idle(1);
      coin(2); sel(1); coin(1);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      drain(); idle(1);

      // Asynchronous reset in the middle of change return
      coin(2);
      step(0, 0, 0, 0, 1, 0, 0, 0);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_change_req", int'(bus.o_change_req), 0);
      chk("async_credit", int'(bus.o_credit), 0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      idle(2);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         int idx;
         if ($urandom_range(0, 99) == 0) begin
            for (int k = 0; k < NI; k++) price[k] = $urandom_range(0, 7);
         end
         idx = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
         step($urandom_range(0, 99) < 25, $urandom_range(0, 6),
              $urandom_range(0, 99) < 30, idx,
              $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 3,
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end
      drain();
      idle(2);
      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
